comm_ctrl: RTL

//  Parametrised UART command processor for the console mux. Parses command bytes from uart_rx,

---
 rtl/comm_pkg.sv | 33 +++
 rtl/comm_ctrl_resp_fifo.sv | 49 ++++
 rtl/comm_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the console-mux command processor: opcodes, reply codes,
// FSM state encodings and small elaboration-time width helpers.
package comm_pkg;

    localparam logic [7:0] CMD_RD_MASK  = 8'h01;
    localparam logic [7:0] CMD_RD_MAP   = 8'h02;
    localparam logic [7:0] CMD_WR_MASK  = 8'h03;
    localparam logic [7:0] CMD_WR_MAP   = 8'h04;
    localparam logic [7:0] CODE_NAK     = 8'hFF;
    localparam logic [7:0] CODE_TIMEOUT = 8'hFE;

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_PAYLOAD = 2'd1,
        P_RESP    = 2'd2,
        P_NAK     = 2'd3
    } parse_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_BUSY = 2'd1,
        D_WAIT = 2'd2
    } drain_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/comm_ctrl_resp_fifo.sv
// Synchronous first-word-fall-through FIFO holding reply bytes; full/empty come from
// read/write pointers carrying an extra wrap bit. Pushes while full are ignored.
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Pointer update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/comm_ctrl.sv
// UART command processor for the console mux: parses commands, holds enable mask and
// pin map with atomic commit, and drains a reply FIFO into uart_tx.
module comm_ctrl
    import comm_pkg::*;
#(
    parameter int INPUT_COUNT    = 4,
    parameter int OUTPUT_COUNT   = 16,
    parameter int RESP_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter logic [OUTPUT_COUNT-1:0] ENABLE_RESET = '1,
    parameter logic [OUTPUT_COUNT*comm_pkg::sel_width(INPUT_COUNT)-1:0] MAP_RESET = '0
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  rx_valid,
    input  logic [7:0]                                            rx_data,
    input  logic                                                  tx_done,
    output logic                                                  tx_start,
    output logic [7:0]                                            tx_data,
    output logic [OUTPUT_COUNT-1:0]                               enabled_out,
    output logic [OUTPUT_COUNT*comm_pkg::sel_width(INPUT_COUNT)-1:0] selectors,
    output logic                                                  resp_ovf
);

    localparam int SEL_W      = sel_width(INPUT_COUNT);
    localparam int MAP_W      = OUTPUT_COUNT * SEL_W;
    localparam int MASK_BYTES = bytes_for(OUTPUT_COUNT);
    localparam int MAP_BYTES  = bytes_for(MAP_W);
    localparam int MAX_BYTES  = (MAP_BYTES > MASK_BYTES) ? MAP_BYTES : MASK_BYTES;
    localparam int SH_W       = MAX_BYTES * 8;
    localparam int CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int TMR_W      = $clog2(TIMEOUT_CYCLES + 1);

    if (((RESP_DEPTH & (RESP_DEPTH - 1)) != 0) || (RESP_DEPTH < MAP_BYTES + 1)) begin : g_bad_depth
        $error("comm_ctrl: RESP_DEPTH must be a power of 2 and at least MAP_BYTES+1");
    end

    parse_state_e            p_state_q, p_state_d;
    drain_state_e            d_state_q, d_state_d;
    logic                    is_map_q, is_map_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SH_W-1:0]         shadow_q, shadow_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [OUTPUT_COUNT-1:0] enabled_q, enabled_d;
    logic [MAP_W-1:0]        sel_q, sel_d;
    logic                    ovf_q;
    logic [7:0]              tx_data_q;

    logic                    push_s;
    logic [7:0]              push_data_s;
    logic [CNT_W-1:0]        last_idx_s;
    logic [SH_W-1:0]         resp_word_s;
    logic [SH_W-1:0]         shadow_wr_s;
    logic [7:0]              fifo_head_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic                    tx_start_s;

    resp_fifo #(
        .WIDTH (8),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (push_data_s),
        .pop_i   (tx_start_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign last_idx_s  = is_map_q ? CNT_W'(MAP_BYTES - 1) : CNT_W'(MASK_BYTES - 1);
    assign resp_word_s = is_map_q ? SH_W'(sel_q) : SH_W'(enabled_q);

    // Parser next-state: command decode, payload shadowing, commit, timeout and replies.
    always_comb begin
        p_state_d   = p_state_q;
        is_map_d    = is_map_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        timer_d     = timer_q;
        enabled_d   = enabled_q;
        sel_d       = sel_q;
        push_s      = 1'b0;
        push_data_s = 8'h00;
        shadow_wr_s = shadow_q;
        shadow_wr_s[{cnt_q, 3'b000} +: 8] = rx_data;

        case (p_state_q)
            P_IDLE: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    case (rx_data)
                        CMD_RD_MASK: begin
                            is_map_d  = 1'b0;
                            p_state_d = P_RESP;
                        end
                        CMD_RD_MAP: begin
                            is_map_d  = 1'b1;
                            p_state_d = P_RESP;
                        end
                        CMD_WR_MASK: begin
                            is_map_d  = 1'b0;
                            shadow_d  = '0;
                            timer_d   = TMR_W'(TIMEOUT_CYCLES);
                            p_state_d = P_PAYLOAD;
                        end
                        CMD_WR_MAP: begin
                            is_map_d  = 1'b1;
                            shadow_d  = '0;
                            timer_d   = TMR_W'(TIMEOUT_CYCLES);
                            p_state_d = P_PAYLOAD;
                        end
                        default: begin
                            p_state_d = P_NAK;
                        end
                    endcase
                end else begin
                    p_state_d = P_IDLE;
                end
            end
            P_PAYLOAD: begin
                if (rx_valid) begin
                    shadow_d = shadow_wr_s;
                    timer_d  = TMR_W'(TIMEOUT_CYCLES);
                    if (cnt_q == last_idx_s) begin
                        // Whole value lands in the live register on one edge.
                        if (is_map_q) begin
                            sel_d = shadow_wr_s[MAP_W-1:0];
                        end else begin
                            enabled_d = shadow_wr_s[OUTPUT_COUNT-1:0];
                        end
                        cnt_d     = '0;
                        p_state_d = P_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (timer_q == '0) begin
                    shadow_d    = '0;
                    push_s      = 1'b1;
                    push_data_s = CODE_TIMEOUT;
                    p_state_d   = P_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            P_RESP: begin
                push_s      = 1'b1;
                push_data_s = resp_word_s[{cnt_q, 3'b000} +: 8];
                if (cnt_q == last_idx_s) begin
                    cnt_d     = '0;
                    p_state_d = P_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            P_NAK: begin
                push_s      = 1'b1;
                push_data_s = CODE_NAK;
                p_state_d   = P_IDLE;
            end
            default: begin
                p_state_d = P_IDLE;
            end
        endcase
    end

    // Parser and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q <= P_IDLE;
            is_map_q  <= 1'b0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            timer_q   <= '0;
            enabled_q <= ENABLE_RESET;
            sel_q     <= MAP_RESET;
            ovf_q     <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            is_map_q  <= is_map_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            timer_q   <= timer_d;
            enabled_q <= enabled_d;
            sel_q     <= sel_d;
            ovf_q     <= ovf_q | (push_s & fifo_full_s);
        end
    end

    // Start is issued in the same cycle the head is seen so a reply can begin two cycles after its command.
    assign tx_start_s = (d_state_q == D_IDLE) && !fifo_empty_s && tx_done && !rst;

    // Drain next-state: start a byte, wait for uart_tx to go busy, then idle again.
    always_comb begin
        d_state_d = d_state_q;
        case (d_state_q)
            D_IDLE: begin
                if (tx_start_s) begin
                    d_state_d = D_BUSY;
                end else begin
                    d_state_d = D_IDLE;
                end
            end
            D_BUSY: begin
                if (!tx_done) begin
                    d_state_d = D_WAIT;
                end else begin
                    d_state_d = D_BUSY;
                end
            end
            D_WAIT: begin
                if (tx_done) begin
                    d_state_d = D_IDLE;
                end else begin
                    d_state_d = D_WAIT;
                end
            end
            default: begin
                d_state_d = D_IDLE;
            end
        endcase
    end

    // Drain state and held transmit byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state_q <= D_IDLE;
            tx_data_q <= 8'h00;
        end else begin
            d_state_q <= d_state_d;
            if (tx_start_s) begin
                tx_data_q <= fifo_head_s;
            end
        end
    end

    assign tx_start    = tx_start_s;
    assign tx_data     = tx_start_s ? fifo_head_s : tx_data_q;
    assign enabled_out = enabled_q;
    assign selectors   = sel_q;
    assign resp_ovf    = ovf_q;

endmodule
